// File: rtl/airi5c_normalizer.sv
// Two-stage normalizer between an FPU arithmetic core and post-processing.
// Stage 1 captures the operand and its leading-zero count; stage 2 shifts and rounds off.
module airi5c_normalizer #(
  parameter int unsigned MAN_W = 48
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             kill,
  input  logic             load,
  input  logic [2:0]       rm_in,
  input  logic [MAN_W-1:0] man_in,
  input  logic [9:0]       exp_in,
  input  logic             sgn_in,
  input  logic             sticky_in,
  input  logic             final_res_in,
  input  logic             IV_in,
  input  logic             DZ_in,
  output logic [2:0]       rm,
  output logic [23:0]      man,
  output logic [9:0]       Exp,
  output logic             sgn,
  output logic             round_bit,
  output logic             sticky_bit,
  output logic             final_res,
  output logic             IV,
  output logic             DZ,
  output logic             ready
);

  localparam int unsigned LzcW = $clog2(MAN_W + 1);

  logic [LzcW-1:0]  lzc;

  logic             s1_valid;
  logic [2:0]       s1_rm;
  logic [MAN_W-1:0] s1_man;
  logic [9:0]       s1_exp;
  logic             s1_sgn;
  logic             s1_sticky;
  logic             s1_final;
  logic             s1_iv;
  logic             s1_dz;
  logic [LzcW-1:0]  s1_lzc;

  logic [MAN_W-1:0]  sh;
  logic signed [10:0] exp_wide;
  logic [9:0]        exp_norm;
  logic              s1_zero;

  // Lowest-to-highest scan: the last hit is the most significant set bit.
  always_comb begin
    lzc = LzcW'(MAN_W);
    for (int i = 0; i < int'(MAN_W); i++) begin
      if (man_in[i]) lzc = LzcW'(int'(MAN_W) - 1 - i);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      s1_valid  <= 1'b0;
      s1_rm     <= '0;
      s1_man    <= '0;
      s1_exp    <= '0;
      s1_sgn    <= 1'b0;
      s1_sticky <= 1'b0;
      s1_final  <= 1'b0;
      s1_iv     <= 1'b0;
      s1_dz     <= 1'b0;
      s1_lzc    <= '0;
    end else if (kill) begin
      s1_valid  <= 1'b0;
      s1_rm     <= '0;
      s1_man    <= '0;
      s1_exp    <= '0;
      s1_sgn    <= 1'b0;
      s1_sticky <= 1'b0;
      s1_final  <= 1'b0;
      s1_iv     <= 1'b0;
      s1_dz     <= 1'b0;
      s1_lzc    <= '0;
    end else begin
      s1_valid <= load;
      if (load) begin
        s1_rm     <= rm_in;
        s1_man    <= man_in;
        s1_exp    <= exp_in;
        s1_sgn    <= sgn_in;
        s1_sticky <= sticky_in;
        s1_final  <= final_res_in;
        s1_iv     <= IV_in;
        s1_dz     <= DZ_in;
        s1_lzc    <= lzc;
      end
    end
  end

  assign sh       = s1_man << s1_lzc;
  assign s1_zero  = (s1_lzc == LzcW'(MAN_W));
  assign exp_wide = {s1_exp[9], s1_exp} + 11'd1 - 11'(s1_lzc);

  // Clamp keeps the downstream bias addition (Exp + 127) from wrapping.
  always_comb begin
    if (exp_wide < -11'sd256)     exp_norm = 10'h300;
    else if (exp_wide > 11'sd255) exp_norm = 10'h0FF;
    else                          exp_norm = exp_wide[9:0];
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ready      <= 1'b0;
      rm         <= '0;
      man        <= '0;
      Exp        <= '0;
      sgn        <= 1'b0;
      round_bit  <= 1'b0;
      sticky_bit <= 1'b0;
      final_res  <= 1'b0;
      IV         <= 1'b0;
      DZ         <= 1'b0;
    end else if (kill) begin
      ready      <= 1'b0;
      rm         <= '0;
      man        <= '0;
      Exp        <= '0;
      sgn        <= 1'b0;
      round_bit  <= 1'b0;
      sticky_bit <= 1'b0;
      final_res  <= 1'b0;
      IV         <= 1'b0;
      DZ         <= 1'b0;
    end else begin
      ready <= s1_valid;
      if (s1_valid) begin
        rm        <= s1_rm;
        sgn       <= s1_sgn;
        final_res <= s1_final;
        IV        <= s1_final & s1_iv;
        DZ        <= s1_final & s1_dz;
        if (s1_final) begin
          man        <= {1'b0, s1_man[22:0]};
          Exp        <= s1_exp;
          round_bit  <= 1'b0;
          sticky_bit <= 1'b0;
        end else if (s1_zero) begin
          man        <= '0;
          Exp        <= 10'h381;
          round_bit  <= 1'b0;
          sticky_bit <= s1_sticky;
        end else begin
          man        <= sh[MAN_W-1 -: 24];
          Exp        <= exp_norm;
          round_bit  <= sh[MAN_W-25];
          sticky_bit <= (|sh[MAN_W-26:0]) | s1_sticky;
        end
      end
    end
  end

endmodule

// File: doc/airi5c_normalizer.md
Name: airi5c_normalizer

Overview:
- Two-stage pipelined normalizer directly upstream of the FPU post-processing stage (rounding, denormalization, exception flags).
- Takes a raw, unnormalized wide mantissa and an unbiased exponent from an arithmetic core, e.g. the multiplier's 48-bit product.
- Left-normalizes the mantissa via leading-zero count and adjusts the exponent.
- Outputs the 24-bit mantissa, round bit, sticky bit and load strobe in the exact format the post-processing stage consumes.

Parameters:
- MAN_W, 48: input mantissa width; legal range ≥ 26. Bit MAN_W-2 carries weight 2^exp_in; bit MAN_W-1 is the overflow position.

Ports:
- clk  input  1  clock
- n_reset  input  1  reset, asynchronous, active-low
- kill  input  1  synchronous flush of both stages
- load  input  1  accept a new operand this cycle
- rm_in  input  3  rounding mode, passed through
- man_in  input  MAN_W  raw mantissa
- exp_in  input  10  unbiased exponent, two's complement
- sgn_in  input  1  sign
- sticky_in  input  1  upstream sticky (discarded bits)
- final_res_in  input  1  operand is an already-final special result (NaN/Inf/zero)
- IV_in  input  1  invalid flag for a final result
- DZ_in  input  1  divide-by-zero flag for a final result
- rm  output  3  registered rounding mode
- man  output  24  normalized mantissa; MSB = 1 unless zero
- Exp  output  10  unbiased exponent, two's complement
- sgn  output  1  sign
- round_bit  output  1  first bit below man
- sticky_bit  output  1  OR of all lower bits and sticky_in
- final_res  output  1  passthrough
- IV  output  1  passthrough
- DZ  output  1  passthrough
- ready  output  1  one-cycle strobe; wired to post-processing load

Behaviour:
- Reset: all outputs and internal registers 0. ready=0, stage valids=0.
- Pipeline, fully pipelined, one operand per cycle:
  - S1, on load: registers all inputs and computes lzc = leading zeros of man_in (0..MAN_W).
  - S2: performs the shift and registers the outputs.
  - Load at cycle N gives ready=1 in cycle N+2 for exactly one cycle.
  - Outputs hold their value until the next result.
- Normal path (final_res_in=0):
  - sh = man_in << lzc
  - man = sh[MAN_W-1:MAN_W-24]
  - round_bit = sh[MAN_W-25]
  - sticky_bit = |sh[MAN_W-26:0] | sticky_in
  - Exp = exp_in + 1 - lzc, computed in 11-bit signed, then clamped to [-256, +255]. The clamp guarantees the downstream Exp+127 neither wraps nor overflows.
- Zero mantissa (lzc = MAN_W):
  - man = 0, round_bit = 0, Exp = 10'h381 (-127), sticky_bit = sticky_in.
  - Downstream then yields ±0, or a tiny inexact denormal.
- Final path (final_res_in=1):
  - No shift: man = {1'b0, man_in[22:0]}, Exp = exp_in.
  - round_bit = 0, sticky_bit = 0.
  - IV/DZ = IV_in/DZ_in.
- IV/DZ are forced 0 for non-final operands.
- sgn and rm pass through unchanged on both paths.
- kill has priority over load.
  - kill in any cycle clears both stage valids, ready and all output registers to 0.
  - Operands in flight are dropped; no ready for them.
  - A load in the same cycle as kill is ignored.
- No backpressure: the consumer always accepts on ready.
- Reset asserted mid-operation behaves like kill, asynchronously.

Test Plan:
- 1.5×1.5: man_in=48'h9000_0000_0000, exp_in=0, load → 2 cycles later ready=1, man=24'h900000, Exp=1, round=0, sticky=0.
- 1.0×1.0: man_in=48'h4000_0000_0000, exp_in=0 → man=24'h800000, Exp=0, round=0, sticky=0.
- Round/sticky: man_in=48'h4000_0060_0000, exp_in=3 → man=24'h800000, Exp=3, round=1, sticky=1.
- Zero and clamps:
  - man_in=0, sticky_in=0 → man=0, Exp=10'h381, round=0, sticky=0.
  - man_in bit47 set, exp_in=496 → Exp=10'h0FF.
  - man_in=1, exp_in=-250 → Exp=10'h300.
- Final passthrough: final_res_in=1, man_in[22:0]=23'h400000, exp_in=10'h0FF, IV_in=1 → man=24'h400000, Exp=10'h0FF, IV=1, final_res=1, round=sticky=0.
- Pipeline and kill:
  - Loads on cycles 0,1,2 → ready on cycles 2,3,4 with results in order.
  - Load at cycle 0 with kill at cycle 1 → no ready in cycle 2, outputs 0.
